uart_rx_frontend: RTL and testbench

Serial receive front end feeding the packet controller. Synchronises the asynchronous `rx` line, recovers 8N1 UART frames LSB-first, and presents each byte as `data` with a one-cycle `valid` strobe. The strobe drives the controller's byte-strobe input, and `data` drives its byte input. Also reports framing errors and provides an inter-byte idle timeout so the controller can resynchronise a stalled packet.

---
 rtl/uart_rx_frontend.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front end: two-flop synchroniser, mid-bit sampling FSM,
// one-cycle byte/framing-error strobes and an inter-byte idle timeout.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IDLE_BITS    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       timeout,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [23:0]      IDLE_M1  = 24'(IDLE_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    logic             sync1_r;
    logic             rx_s;
    state_t           state_r;
    state_t           state_n_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n_s;
    logic [2:0]       bitn_r;
    logic [2:0]       bitn_n_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_n_s;
    logic [7:0]       data_n_s;
    logic             valid_n_s;
    logic             frame_err_n_s;
    logic             good_s;
    logic             armed_r;
    logic [23:0]      idle_cnt_r;

    // Two-flop synchroniser; idles high so reset cannot fake a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx;
            rx_s    <= sync1_r;
        end
    end

    // Next-state and strobe decode for the frame FSM.
    always_comb begin
        state_n_s     = state_r;
        cnt_n_s       = cnt_r;
        bitn_n_s      = bitn_r;
        shift_n_s     = shift_r;
        data_n_s      = data;
        valid_n_s     = 1'b0;
        frame_err_n_s = 1'b0;
        good_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n_s = CNT_ZERO;
                if (!rx_s) begin
                    state_n_s = ST_START;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_n_s  = CNT_ZERO;
                    bitn_n_s = 3'd0;
                    if (!rx_s) begin
                        state_n_s = ST_DATA;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    cnt_n_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_M1) begin
                    shift_n_s = {rx_s, shift_r[7:1]};
                    cnt_n_s   = CNT_ZERO;
                    bitn_n_s  = bitn_r + 3'd1;
                    if (bitn_r == 3'd7) begin
                        state_n_s = ST_STOP;
                    end else begin
                        state_n_s = ST_DATA;
                    end
                end else begin
                    cnt_n_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_M1) begin
                    cnt_n_s = CNT_ZERO;
                    if (rx_s) begin
                        data_n_s  = shift_r;
                        valid_n_s = 1'b1;
                        good_s    = 1'b1;
                        state_n_s = ST_IDLE;
                    end else begin
                        frame_err_n_s = 1'b1;
                        state_n_s     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_n_s = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low break must not re-trigger a start until the line recovers.
                if (rx_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                cnt_n_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state, datapath and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bitn_r    <= 3'd0;
            shift_r   <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            cnt_r     <= cnt_n_s;
            bitn_r    <= bitn_n_s;
            shift_r   <= shift_n_s;
            data      <= data_n_s;
            valid     <= valid_n_s;
            frame_err <= frame_err_n_s;
            busy      <= (state_n_s != ST_IDLE);
        end
    end

    // Idle timer: armed by a good byte, counts only in IDLE, a start edge cancels it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_r    <= 1'b0;
            idle_cnt_r <= 24'd0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (good_s) begin
                armed_r    <= 1'b1;
                idle_cnt_r <= 24'd0;
            end else if (state_r != ST_IDLE) begin
                idle_cnt_r <= 24'd0;
            end else if (!rx_s) begin
                armed_r    <= 1'b0;
                idle_cnt_r <= 24'd0;
            end else if (armed_r) begin
                if (idle_cnt_r == IDLE_M1) begin
                    timeout    <= 1'b1;
                    armed_r    <= 1'b0;
                    idle_cnt_r <= 24'd0;
                end else begin
                    idle_cnt_r <= idle_cnt_r + 24'd1;
                end
            end else begin
                idle_cnt_r <= 24'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: frame table plus hand sequences,
// with a cycle-stamped scoreboard of expected valid/frame_err/timeout pulses.
module tb_uart_rx_frontend;

    localparam int CPB = 16;
    localparam int IDB = 4;
    // Pin-change cycle P of a start bit -> strobe at P+2 (sync) +8 (half) +144 +1.
    localparam int STROBE_OFS  = 2 + CPB / 2 + 9 * CPB + 1;
    localparam int TIMEOUT_OFS = STROBE_OFS + IDB * CPB;
    // Idle cycles after the stop bit needed for the timer to expire first.
    localparam int TO_MIN_GAP  = TIMEOUT_OFS - 10 * CPB - 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       timeout;
    logic       busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] dat;
        int         at;
    } ev_t;

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        int         hold;
        int         gap;
        logic [2:0] exp_kind;
        logic [7:0] exp_data;
        logic       exp_to;
    } vec_t;

    ev_t  exp_q[$];
    vec_t tbl[7];

    uart_rx_frontend #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .valid(valid), .frame_err(frame_err), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && (valid || frame_err || timeout)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got v/f/t=%b at cycle %0d expected none",
                         {valid, frame_err, timeout}, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", {29'd0, valid, frame_err, timeout}, {29'd0, e.kind});
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_data", {24'd0, data}, {24'd0, e.dat});
            end
        end
    end

    task automatic bit_time(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Caller must be 1 time unit after a rising edge.
    task automatic send_frame(input vec_t v);
        int  p;
        ev_t e;
        p     = cyc;
        e.kind = v.exp_kind;
        e.dat  = v.exp_data;
        e.at   = p + STROBE_OFS;
        exp_q.push_back(e);
        if (v.exp_to) begin
            e.kind = 3'b001;
            e.at   = p + TIMEOUT_OFS;
            exp_q.push_back(e);
        end
        bit_time(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_time(v.byte_v[i], CPB);
        bit_time(v.stop_v, CPB);
        if (v.hold > 0) bit_time(1'b0, v.hold);
        if (v.gap > 0) bit_time(1'b1, v.gap);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int   p;
        vec_t v;

        tbl[0] = '{8'h00, 1'b1, 0, 0,  3'b100, 8'h00, 1'b0};
        tbl[1] = '{8'hFF, 1'b1, 0, 30, 3'b100, 8'hFF, 1'b0};
        tbl[2] = '{8'h3C, 1'b0, 48, 20, 3'b010, 8'hFF, 1'b0};
        tbl[3] = '{8'h81, 1'b1, 0, 20, 3'b100, 8'h81, 1'b0};
        tbl[4] = '{8'h55, 1'b1, 0, 80, 3'b100, 8'h55, 1'b1};
        tbl[5] = '{8'h55, 1'b1, 0, TO_MIN_GAP - 22, 3'b100, 8'h55, 1'b0};
        tbl[6] = '{8'h5A, 1'b1, 0, 70, 3'b100, 8'h5A, 1'b1};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        bit_time(1'b1, 100);

        // 0xA5 with busy window check around the frame.
        v = '{8'hA5, 1'b1, 0, 70, 3'b100, 8'hA5, 1'b1};
        p = cyc;
        fork
            send_frame(v);
            begin
                at_cycle(p + 2);
                chk("busy_t0", {31'd0, busy}, 32'd0);
                at_cycle(p + 3);
                chk("busy_t0p1", {31'd0, busy}, 32'd1);
                at_cycle(p + STROBE_OFS - 1);
                chk("busy_last", {31'd0, busy}, 32'd1);
                at_cycle(p + STROBE_OFS);
                chk("busy_valid_cycle", {31'd0, busy}, 32'd0);
            end
        join

        for (int i = 0; i < 7; i++) send_frame(tbl[i]);

        // Four-cycle glitch: rejected at the start sample.
        p = cyc;
        bit_time(1'b0, 4);
        rx = 1'b1;
        at_cycle(p + 2 + CPB / 2);
        chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
        at_cycle(p + 2 + CPB / 2 + 1);
        chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
        chk("glitch_data", {24'd0, data}, 32'h5A);
        @(posedge clk);
        #1;
        bit_time(1'b1, 30);

        // Reset during data bit 3 of 0x96.
        v.byte_v = 8'h96;
        bit_time(1'b0, CPB);
        for (int i = 0; i < 3; i++) bit_time(v.byte_v[i], CPB);
        rx = v.byte_v[3];
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_data", {24'd0, data}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_timeout", {31'd0, timeout}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bit_time(1'b1, 100);
        v = '{8'hC3, 1'b1, 0, 70, 3'b100, 8'hC3, 1'b1};
        send_frame(v);

        bit_time(1'b1, 100);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
